// File: rtl/cnt5_wrap_tracker.sv
// Observes a mod-5 up/down count, classifies each edge-to-edge transition,
// keeps a wrapping lap count, a sticky error flag and a registered 7-seg view.
module cnt5_wrap_tracker #(
    parameter int unsigned LAP_MAX        = 9,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] cnt,
    input  logic       err_clr,
    output logic       carry,
    output logic       borrow,
    output logic [3:0] lap,
    output logic       err,
    output logic [6:0] seg
);

    localparam logic [3:0] LAP_TOP  = 4'(LAP_MAX);
    localparam logic [6:0] SEG_INV  = {7{SEG_ACTIVE_LOW}};
    localparam logic [6:0] SEG_ZERO = 7'b1111110 ^ SEG_INV;

    logic [2:0] prev_cnt_reg;
    logic       carry_reg;
    logic       borrow_reg;
    logic [3:0] lap_reg;
    logic       err_reg;
    logic [6:0] seg_reg;

    logic       is_hold;
    logic       is_up;
    logic       is_down;
    logic       is_carry;
    logic       is_borrow;
    logic       is_illegal;
    logic [3:0] lap_next;
    logic       err_next;
    logic [6:0] seg_next;

    // Rules are evaluated in priority order; the first one that matches wins.
    always_comb begin
        is_hold    = 1'b0;
        is_up      = 1'b0;
        is_down    = 1'b0;
        is_carry   = 1'b0;
        is_borrow  = 1'b0;
        is_illegal = 1'b0;
        if (cnt == prev_cnt_reg) begin
            is_hold = 1'b1;
        end else if ((prev_cnt_reg < 3'd4) && (cnt == prev_cnt_reg + 3'd1)) begin
            is_up = 1'b1;
        end else if ((prev_cnt_reg > 3'd0) && (prev_cnt_reg <= 3'd4)
                     && (cnt == prev_cnt_reg - 3'd1)) begin
            is_down = 1'b1;
        end else if ((prev_cnt_reg == 3'd4) && (cnt == 3'd0)) begin
            is_carry = 1'b1;
        end else if ((prev_cnt_reg == 3'd0) && (cnt == 3'd4)) begin
            is_borrow = 1'b1;
        end else begin
            is_illegal = 1'b1;
        end
    end

    always_comb begin
        lap_next = lap_reg;
        if (is_carry) begin
            lap_next = (lap_reg == LAP_TOP) ? 4'd0 : lap_reg + 4'd1;
        end else if (is_borrow) begin
            lap_next = (lap_reg == 4'd0) ? LAP_TOP : lap_reg - 4'd1;
        end
    end

    // A fresh illegal event takes priority over a clear request.
    always_comb begin
        err_next = err_reg;
        if (is_illegal) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
    end

    always_comb begin
        seg_next = 7'b0000001;
        case (cnt)
            3'd0:    seg_next = 7'b1111110;
            3'd1:    seg_next = 7'b0110000;
            3'd2:    seg_next = 7'b1101101;
            3'd3:    seg_next = 7'b1111001;
            3'd4:    seg_next = 7'b0110011;
            default: seg_next = 7'b0000001;
        endcase
        seg_next = seg_next ^ SEG_INV;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_cnt_reg <= 3'd0;
            carry_reg    <= 1'b0;
            borrow_reg   <= 1'b0;
            lap_reg      <= 4'd0;
            err_reg      <= 1'b0;
            seg_reg      <= SEG_ZERO;
        end else begin
            prev_cnt_reg <= cnt;
            carry_reg    <= is_carry;
            borrow_reg   <= is_borrow;
            lap_reg      <= lap_next;
            err_reg      <= err_next;
            seg_reg      <= seg_next;
        end
    end

    assign carry  = carry_reg;
    assign borrow = borrow_reg;
    assign lap    = lap_reg;
    assign err    = err_reg;
    assign seg    = seg_reg;

endmodule

// File: tb/tb_cnt5_wrap_tracker.sv
// Scoreboard bench for cnt5_wrap_tracker: a reference model predicts each
// cycle's outputs when cnt is driven; they are compared after the clock edge.
module tb_cnt5_wrap_tracker;

    localparam int LAP_MAX = 9;

    typedef struct {
        logic       carry;
        logic       borrow;
        logic [3:0] lap;
        logic       err;
        logic [6:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] cnt;
    logic       err_clr;
    logic       carry;
    logic       borrow;
    logic [3:0] lap;
    logic       err;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    int         m_prev;
    int         m_lap;
    bit         m_err;
    logic [6:0] seg_tbl [0:7];

    cnt5_wrap_tracker #(.LAP_MAX(LAP_MAX), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cnt     (cnt),
        .err_clr (err_clr),
        .carry   (carry),
        .borrow  (borrow),
        .lap     (lap),
        .err     (err),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_carry"},  32'(carry),  32'd0);
        check_eq({tag, "_borrow"}, 32'(borrow), 32'd0);
        check_eq({tag, "_lap"},    32'(lap),    32'd0);
        check_eq({tag, "_err"},    32'(err),    32'd0);
        check_eq({tag, "_seg"},    32'(seg),    32'b1111110);
    endtask

    task automatic model_reset();
        m_prev = 0;
        m_lap  = 0;
        m_err  = 1'b0;
    endtask

    // Drive one cnt value, predict the post-edge outputs, then compare.
    task automatic step(input int c, input bit clr);
        exp_t e;
        exp_t got;
        int   d;
        bit   ill;
        @(negedge clk);
        cnt     = 3'(c);
        err_clr = clr;
        e.carry  = 1'b0;
        e.borrow = 1'b0;
        ill      = 1'b0;
        if (c == m_prev) begin
            ill = 1'b0;
        end else if (m_prev <= 4 && c <= 4) begin
            d = (c - m_prev + 5) % 5;
            if (d == 1 && m_prev != 4) ill = 1'b0;
            else if (d == 4 && m_prev != 0) ill = 1'b0;
            else if (m_prev == 4 && c == 0) e.carry = 1'b1;
            else if (m_prev == 0 && c == 4) e.borrow = 1'b1;
            else ill = 1'b1;
        end else begin
            ill = 1'b1;
        end
        if (e.carry)  m_lap = (m_lap + 1) % (LAP_MAX + 1);
        if (e.borrow) m_lap = (m_lap + LAP_MAX) % (LAP_MAX + 1);
        if (ill) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        m_prev = c;
        e.lap = 4'(m_lap);
        e.err = m_err;
        e.seg = seg_tbl[c];
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check_eq("carry",  32'(carry),  32'(got.carry));
            check_eq("borrow", 32'(borrow), 32'(got.borrow));
            check_eq("lap",    32'(lap),    32'(got.lap));
            check_eq("err",    32'(err),    32'(got.err));
            check_eq("seg",    32'(seg),    32'(got.seg));
            $display("step cnt=%0d clr=%0d -> carry=%0d borrow=%0d lap=%0d err=%0d seg=%07b",
                     c, clr, carry, borrow, lap, err, seg);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tbl[0] = 7'b1111110;
        seg_tbl[1] = 7'b0110000;
        seg_tbl[2] = 7'b1101101;
        seg_tbl[3] = 7'b1111001;
        seg_tbl[4] = 7'b0110011;
        seg_tbl[5] = 7'b0000001;
        seg_tbl[6] = 7'b0000001;
        seg_tbl[7] = 7'b0000001;
        model_reset();

        reset_n = 1'b0;
        cnt     = 3'd0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Idle at zero.
        repeat (3) step(0, 1'b0);

        // One full up lap with carry.
        for (int i = 1; i <= 5; i++) step(i % 5, 1'b0);

        // Borrows: lap 1 -> 0, then walk down and borrow again to LAP_MAX.
        step(4, 1'b0);
        step(3, 1'b0);
        step(2, 1'b0);
        step(1, 1'b0);
        step(0, 1'b0);
        step(4, 1'b0);
        step(3, 1'b0);
        step(4, 1'b0);
        step(0, 1'b0);

        // Ten consecutive up wraps.
        for (int w = 0; w < 10; w++) begin
            for (int i = 1; i <= 5; i++) step(i % 5, 1'b0);
        end

        // 4/0 toggling every cycle: back-to-back pulses.
        step(4, 1'b0);
        step(0, 1'b0);
        step(4, 1'b0);
        step(0, 1'b0);

        // Illegal jumps, dash display, err_clr behaviour.
        step(1, 1'b0);
        step(3, 1'b0);
        step(6, 1'b0);
        step(7, 1'b1);
        step(0, 1'b1);
        step(0, 1'b1);
        step(1, 1'b0);
        step(5, 1'b1);
        step(0, 1'b1);
        step(0, 1'b1);
        step(0, 1'b0);

        // Reach lap 5 with cnt 3, then reset asynchronously mid-cycle.
        for (int w = 0; w < 5; w++) begin
            for (int i = 1; i <= 5; i++) step(i % 5, 1'b0);
        end
        step(1, 1'b0);
        step(2, 1'b0);
        step(3, 1'b0);
        check_eq("pre_reset_lap", 32'(lap), 32'd5);
        #2;
        reset_n = 1'b0;
        cnt     = 3'd0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1'b0);
        step(0, 1'b0);
        step(1, 1'b0);
        step(0, 1'b0);
        step(4, 1'b0);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
